// File: rtl/rx_tlp_sender.sv
// Drains QWORDs from the rx buffer into posted 64-bit memory-write TLPs (4DW header) aimed at
// the current host huge page, and writes the page fill count into QW 0 when a page is closed.
`ifndef BF
`define BF 4
`endif

module rx_tlp_sender #(
  parameter int unsigned RESERVED_QW = 16,
  parameter int unsigned TLP_QW_MAX  = 16,
  parameter logic [7:0]  TAG         = 8'h00
) (
  input  logic              clk250,
  input  logic              reset_n,
  input  logic              trigger_tlp,
  input  logic              change_huge_page,
  input  logic              send_last_tlp_change_huge_page,
  input  logic [4:0]        qwords_to_send,
  output logic              trigger_tlp_ack,
  output logic              change_huge_page_ack,
  output logic [`BF+1:0]    commited_rd_address,
  output logic [`BF:0]      rd_addr,
  input  logic [63:0]       rd_data,
  input  logic [63:0]       huge_page_addr,
  input  logic              huge_page_available,
  output logic              huge_page_closed,
  input  logic [15:0]       cfg_completer_id,
  output logic [63:0]       trn_td,
  output logic [7:0]        trn_trem_n,
  output logic              trn_tsof_n,
  output logic              trn_teof_n,
  output logic              trn_tsrc_rdy_n,
  input  logic              trn_tdst_rdy_n
);

  localparam int BFW = `BF;

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, DATA, CLOSE_GAP, CLOSE_HDR0, CLOSE_HDR1, CLOSE_DATA, ACK_TRIG, ACK_CHG
  } state_t;

  state_t        state;
  logic          trigger_reg;
  logic          change_reg;
  logic          send_last_reg;
  logic [4:0]    qw_req_reg;
  logic [4:0]    qw_cur;
  logic [4:0]    beat_cnt;
  logic          close_after;
  logic [BFW:0]  rd_ptr;
  logic [18:0]   page_qw;
  logic          beat_ok;
  logic          last_beat;
  logic          load_qw;

  function automatic logic [63:0] wr_hdr(input logic [9:0] len, input logic [15:0] cid);
    return {1'b0, 2'b11, 5'b0, 8'b0, 6'b0, len, cid, TAG, 8'hFF};
  endfunction

  function automatic logic [4:0] clamp_qw(input logic [4:0] q);
    return (q > 5'(TLP_QW_MAX)) ? 5'(TLP_QW_MAX) : q;
  endfunction

  assign trn_trem_n = 8'h00;
  assign beat_ok    = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
  assign last_beat  = (beat_cnt == qw_cur - 5'd1);
  // A QW is pulled into trn_td on the HDR1 handoff and on every non-final data beat; the
  // address runs one ahead on those cycles so the 1-cycle read latency never inserts a bubble.
  assign load_qw    = beat_ok && ((state == HDR1) || ((state == DATA) && !last_beat));
  assign rd_addr    = rd_ptr + (BFW+1)'(load_qw);

  always_ff @(posedge clk250 or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      trigger_reg          <= 1'b0;
      change_reg           <= 1'b0;
      send_last_reg        <= 1'b0;
      qw_req_reg           <= '0;
      qw_cur               <= '0;
      beat_cnt             <= '0;
      close_after          <= 1'b0;
      rd_ptr               <= '0;
      page_qw              <= 19'(RESERVED_QW);
      commited_rd_address  <= '0;
      trigger_tlp_ack      <= 1'b0;
      change_huge_page_ack <= 1'b0;
      huge_page_closed     <= 1'b0;
      trn_td               <= '0;
      trn_tsof_n           <= 1'b1;
      trn_teof_n           <= 1'b1;
      trn_tsrc_rdy_n       <= 1'b1;
    end else begin
      trigger_reg      <= trigger_tlp;
      change_reg       <= change_huge_page;
      send_last_reg    <= send_last_tlp_change_huge_page;
      qw_req_reg       <= qwords_to_send;
      huge_page_closed <= 1'b0;

      case (state)
        IDLE: begin
          if (huge_page_available) begin
            if (trigger_reg || (send_last_reg && qw_req_reg != 5'd0)) begin
              close_after    <= !trigger_reg;
              qw_cur         <= clamp_qw(qw_req_reg);
              trn_td         <= wr_hdr({4'b0, clamp_qw(qw_req_reg), 1'b0}, cfg_completer_id);
              trn_tsof_n     <= 1'b0;
              trn_tsrc_rdy_n <= 1'b0;
              state          <= HDR0;
            end else if (change_reg || send_last_reg) begin
              trn_td         <= wr_hdr(10'd2, cfg_completer_id);
              trn_tsof_n     <= 1'b0;
              trn_tsrc_rdy_n <= 1'b0;
              state          <= CLOSE_HDR0;
            end
          end
        end
        HDR0: if (beat_ok) begin
          trn_td     <= huge_page_addr + 64'({page_qw, 3'b000});
          trn_tsof_n <= 1'b1;
          state      <= HDR1;
        end
        HDR1: if (beat_ok) begin
          trn_td     <= rd_data;
          rd_ptr     <= rd_ptr + 1'b1;
          beat_cnt   <= '0;
          trn_teof_n <= (qw_cur != 5'd1);
          state      <= DATA;
        end
        DATA: if (beat_ok) begin
          if (last_beat) begin
            commited_rd_address <= commited_rd_address + (BFW+2)'(qw_cur);
            page_qw             <= page_qw + 19'(qw_cur);
            trn_td              <= '0;
            trn_teof_n          <= 1'b1;
            trn_tsrc_rdy_n      <= 1'b1;
            if (close_after) begin
              state <= CLOSE_GAP;
            end else begin
              trigger_tlp_ack <= 1'b1;
              state           <= ACK_TRIG;
            end
          end else begin
            trn_td     <= rd_data;
            rd_ptr     <= rd_ptr + 1'b1;
            beat_cnt   <= beat_cnt + 5'd1;
            trn_teof_n <= (beat_cnt + 5'd2 != qw_cur);
          end
        end
        CLOSE_GAP: begin
          trn_td         <= wr_hdr(10'd2, cfg_completer_id);
          trn_tsof_n     <= 1'b0;
          trn_tsrc_rdy_n <= 1'b0;
          state          <= CLOSE_HDR0;
        end
        CLOSE_HDR0: if (beat_ok) begin
          trn_td     <= huge_page_addr;
          trn_tsof_n <= 1'b1;
          state      <= CLOSE_HDR1;
        end
        CLOSE_HDR1: if (beat_ok) begin
          trn_td     <= {45'b0, page_qw};
          trn_teof_n <= 1'b0;
          state      <= CLOSE_DATA;
        end
        CLOSE_DATA: if (beat_ok) begin
          trn_td               <= '0;
          trn_teof_n           <= 1'b1;
          trn_tsrc_rdy_n       <= 1'b1;
          page_qw              <= 19'(RESERVED_QW);
          huge_page_closed     <= 1'b1;
          change_huge_page_ack <= 1'b1;
          state                <= ACK_CHG;
        end
        ACK_TRIG: if (!trigger_reg) begin
          trigger_tlp_ack <= 1'b0;
          state           <= IDLE;
        end
        ACK_CHG: if (!(change_reg || send_last_reg)) begin
          change_huge_page_ack <= 1'b0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_tlp_sender.sv
// Directed bench for rx_tlp_sender: captures every accepted TX beat and compares whole frames
// against hand-computed headers, addresses and buffer contents.
`timescale 1ns/100ps
`ifndef BF
`define BF 4
`endif

module tb_rx_tlp_sender;
  localparam int BFW   = `BF;
  localparam int DEPTH = 1 << (BFW + 1);

  logic              clk250 = 1'b0;
  logic              reset_n = 1'b0;
  logic              trigger_tlp = 1'b0;
  logic              change_huge_page = 1'b0;
  logic              send_last_tlp_change_huge_page = 1'b0;
  logic [4:0]        qwords_to_send = 5'd0;
  logic              trigger_tlp_ack;
  logic              change_huge_page_ack;
  logic [BFW+1:0]    commited_rd_address;
  logic [BFW:0]      rd_addr;
  logic [63:0]       rd_data = '0;
  logic [63:0]       huge_page_addr = 64'h1_0000_0000;
  logic              huge_page_available = 1'b1;
  logic              huge_page_closed;
  logic [15:0]       cfg_completer_id = 16'h0100;
  logic [63:0]       trn_td;
  logic [7:0]        trn_trem_n;
  logic              trn_tsof_n;
  logic              trn_teof_n;
  logic              trn_tsrc_rdy_n;
  logic              trn_tdst_rdy_n = 1'b0;

  rx_tlp_sender dut (
    .clk250(clk250), .reset_n(reset_n),
    .trigger_tlp(trigger_tlp), .change_huge_page(change_huge_page),
    .send_last_tlp_change_huge_page(send_last_tlp_change_huge_page),
    .qwords_to_send(qwords_to_send),
    .trigger_tlp_ack(trigger_tlp_ack), .change_huge_page_ack(change_huge_page_ack),
    .commited_rd_address(commited_rd_address), .rd_addr(rd_addr), .rd_data(rd_data),
    .huge_page_addr(huge_page_addr), .huge_page_available(huge_page_available),
    .huge_page_closed(huge_page_closed), .cfg_completer_id(cfg_completer_id),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tdst_rdy_n(trn_tdst_rdy_n)
  );

  always #2 clk250 = ~clk250;

  typedef struct {
    logic [63:0] td;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t bq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    eof_cyc = 0;
  int    ack_cyc = 0;
  int    closed_pulses = 0;
  int    chg_rises = 0;
  int    trem_bad = 0;
  bit    bp_mode = 1'b0;
  int    bp_cnt = 0;
  logic  chg_ack_q = 1'b0;

  function automatic logic [63:0] qv(input int a);
    return {16'hC0DE, 16'(a), 16'hBEEF, 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // rx buffer model with 1-cycle read latency
  always @(posedge clk250) rd_data <= qv(int'(rd_addr));

  always @(posedge clk250) begin
    cyc++;
    #1;
    bp_cnt++;
    trn_tdst_rdy_n = bp_mode ? bp_cnt[1] : 1'b0;
  end

  always @(negedge clk250) begin
    if (reset_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      bq.push_back('{td: trn_td, sof: !trn_tsof_n, eof: !trn_teof_n});
      if (!trn_teof_n) eof_cyc = cyc;
      if (trn_trem_n != 8'h00) trem_bad++;
    end
    if (huge_page_closed) closed_pulses++;
    if (change_huge_page_ack && !chg_ack_q) chg_rises++;
    chg_ack_q = change_huge_page_ack;
  end

  task automatic check_frame(input string tag, input logic [63:0] hdr, input logic [63:0] addr,
                             input int qw, input int start, input logic [63:0] cval);
    beat_t       b;
    int          ferr;
    logic [63:0] exp;
    if (bq.size() < qw + 2) begin
      chk({tag, "_beats"}, 64'(bq.size()), 64'(qw + 2));
      bq.delete();
      return;
    end
    ferr = 0;
    for (int i = 0; i < qw + 2; i++) begin
      b = bq.pop_front();
      if (i == 0)      exp = hdr;
      else if (i == 1) exp = addr;
      else             exp = (start < 0) ? cval : qv((start + i - 2) % DEPTH);
      chk($sformatf("%s_b%0d", tag, i), b.td, exp);
      if (b.sof !== (i == 0) || b.eof !== (i == qw + 1)) ferr++;
    end
    chk({tag, "_framing"}, 64'(ferr), 64'd0);
  endtask

  task automatic set_req(input int kind, input logic v);
    case (kind)
      0:       trigger_tlp = v;
      1:       change_huge_page = v;
      default: send_last_tlp_change_huge_page = v;
    endcase
  endtask

  // Waits for the ack of the raised request, drops the request, waits for the ack to fall.
  task automatic finish_req(input int kind, input string tag);
    int   n;
    logic a;
    n = 0;
    a = 1'b0;
    while (n < 400 && !a) begin
      @(negedge clk250);
      n++;
      a = (kind == 0) ? trigger_tlp_ack : change_huge_page_ack;
    end
    ack_cyc = cyc;
    chk({tag, "_ack_rise"}, 64'(a), 64'd1);
    set_req(kind, 1'b0);
    n = 0;
    while (n < 10 && a) begin
      @(negedge clk250);
      n++;
      a = (kind == 0) ? trigger_tlp_ack : change_huge_page_ack;
    end
    chk({tag, "_ack_fall"}, 64'(a), 64'd0);
  endtask

  task automatic request(input int kind, input logic [4:0] qw, input string tag);
    @(negedge clk250);
    qwords_to_send = qw;
    set_req(kind, 1'b1);
    finish_req(kind, tag);
    repeat (2) @(negedge clk250);
  endtask

  int n;
  int pulses0;
  int rises0;

  initial begin
    repeat (3) @(negedge clk250);
    chk("rst_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    chk("rst_sof_eof", {62'd0, trn_tsof_n, trn_teof_n}, 64'd3);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_acks", {62'd0, trigger_tlp_ack, change_huge_page_ack}, 64'd0);
    chk("rst_commit", 64'(commited_rd_address), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_closed", 64'(huge_page_closed), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk250);

    // full 16-QW TLP at offset 16
    request(0, 5'd16, "t1");
    check_frame("t1", 64'h6000_0020_0100_00FF, 64'h1_0000_0080, 16, 0, '0);
    chk("t1_commit", 64'(commited_rd_address), 64'd16);
    chk("t1_ack_lat", 64'(ack_cyc), 64'(eof_cyc + 1));

    // same under backpressure, reading buffer QWs 16..31
    bp_mode = 1'b1;
    request(0, 5'd16, "t2");
    bp_mode = 1'b0;
    check_frame("t2", 64'h6000_0020_0100_00FF, 64'h1_0000_0100, 16, 16, '0);
    chk("t2_commit", 64'(commited_rd_address), 64'd32);

    // third TLP: read pointer has wrapped back to 0
    request(0, 5'd16, "t3");
    check_frame("t3", 64'h6000_0020_0100_00FF, 64'h1_0000_0180, 16, 0, '0);
    chk("t3_commit", 64'(commited_rd_address), 64'd48);

    // partial TLP then page close: fill count 64 + 5 = 0x45
    pulses0 = closed_pulses;
    rises0  = chg_rises;
    request(2, 5'd5, "t4");
    check_frame("t4d", 64'h6000_000A_0100_00FF, 64'h1_0000_0200, 5, 16, '0);
    check_frame("t4c", 64'h6000_0002_0100_00FF, 64'h1_0000_0000, 1, -1, 64'h45);
    chk("t4_commit", 64'(commited_rd_address), 64'd53);
    chk("t4_closed", 64'(closed_pulses - pulses0), 64'd1);
    chk("t4_chg_rises", 64'(chg_rises - rises0), 64'd1);
    chk("t4_trig_ack", 64'(trigger_tlp_ack), 64'd0);

    // change alone: close TLP only, fill count back at 16
    pulses0 = closed_pulses;
    request(1, 5'd0, "t5");
    check_frame("t5c", 64'h6000_0002_0100_00FF, 64'h1_0000_0000, 1, -1, 64'h10);
    chk("t5_extra", 64'(bq.size()), 64'd0);
    chk("t5_commit", 64'(commited_rd_address), 64'd53);
    chk("t5_closed", 64'(closed_pulses - pulses0), 64'd1);

    // no page available: trigger stays pending
    huge_page_available = 1'b0;
    @(negedge clk250);
    qwords_to_send = 5'd3;
    trigger_tlp = 1'b1;
    repeat (20) @(negedge clk250);
    chk("t6_held_beats", 64'(bq.size()), 64'd0);
    chk("t6_held_ack", 64'(trigger_tlp_ack), 64'd0);
    huge_page_available = 1'b1;
    finish_req(0, "t6");
    check_frame("t6", 64'h6000_0006_0100_00FF, 64'h1_0000_0080, 3, 21, '0);
    chk("t6_commit", 64'(commited_rd_address), 64'd56);

    // reset while data beat 7 is on the bus
    @(negedge clk250);
    qwords_to_send = 5'd16;
    trigger_tlp = 1'b1;
    n = 0;
    while (n < 200 && bq.size() < 9) begin
      @(posedge clk250);
      n++;
    end
    chk("t7_reached_beat7", 64'(bq.size()), 64'd9);
    #1 reset_n = 1'b0;
    trigger_tlp = 1'b0;
    #0.5;
    chk("t7_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    chk("t7_td", trn_td, 64'd0);
    chk("t7_commit", 64'(commited_rd_address), 64'd0);
    chk("t7_ack", 64'(trigger_tlp_ack), 64'd0);
    repeat (2) @(negedge clk250);
    bq.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk250);
    request(0, 5'd2, "t8");
    check_frame("t8", 64'h6000_0004_0100_00FF, 64'h1_0000_0080, 2, 0, '0);
    chk("t8_extra", 64'(bq.size()), 64'd0);
    chk("t8_commit", 64'(commited_rd_address), 64'd2);
    chk("trem_all_beats", 64'(trem_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
